// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares one single-port data memory between the pipeline MEM stage (CPU)
//   and a DMA/loader port. At most one access is served per cycle. The CPU
//   stalls whenever it is requesting and does not win. DMA traffic runs in
//   bounded bursts. A waiting DMA is forced through after STARVE_LIMIT cycles
//   won by the CPU.
//
// Ports
//   clk, reset                    clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata         CPU access request (MEM stage)
//   cpu_rdata                     load data, combinational from mem_rdata
//   cpu_stall                     CPU requesting but not served this cycle
//   dma_req/we/addr/wdata         DMA access request, held until dma_gnt
//   dma_gnt                       DMA served this cycle
//   dma_rdata, dma_rvalid         registered DMA read data + 1-cycle valid
//   mem_read, mem_write           memory strobes
//   mem_addr, mem_wdata           muxed address / write data (0 when idle)
//   mem_rdata                     combinational memory read data
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_BURST    = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int BEAT_W = $clog2(MAX_BURST + 1);
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(MAX_BURST);
    localparam logic [BEAT_W-1:0] BEAT_ONE = BEAT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t              state_reg, state_next;
    logic [BEAT_W-1:0]   beat_cnt_reg, beat_cnt_next;
    logic [WAIT_W-1:0]   dma_wait_reg, dma_wait_next;
    logic [DATA_W-1:0]   dma_rdata_reg;
    logic                dma_rvalid_reg;
    logic                grant_cpu;
    logic                grant_dma;

    // State register plus DMA read-return register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_ARB;
            beat_cnt_reg   <= '0;
            dma_wait_reg   <= '0;
            dma_rdata_reg  <= '0;
            dma_rvalid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            beat_cnt_reg <= beat_cnt_next;
            dma_wait_reg <= dma_wait_next;
            if (grant_dma && !dma_we) begin
                dma_rdata_reg  <= mem_rdata;
                dma_rvalid_reg <= 1'b1;
            end else begin
                dma_rvalid_reg <= 1'b0;
            end
        end
    end

    // Next-state logic. It is driven by the grant decision made below.
    always_comb begin
        state_next    = state_reg;
        beat_cnt_next = beat_cnt_reg;
        dma_wait_next = dma_wait_reg;
        case (state_reg)
            ST_ARB: begin
                if (grant_cpu) begin
                    // Count CPU wins while the DMA waits. The count saturates so it never wraps.
                    if (dma_req && (dma_wait_reg < WAIT_MAX))
                        dma_wait_next = dma_wait_reg + WAIT_ONE;
                end else if (grant_dma) begin
                    dma_wait_next = '0;
                    beat_cnt_next = BEAT_ONE;
                    state_next    = ST_BURST;
                end
            end
            ST_BURST: begin
                if (grant_dma) begin
                    // A full burst restarts at beat 1 only when the CPU is not requesting.
                    beat_cnt_next = (beat_cnt_reg < BEAT_MAX) ? beat_cnt_reg + BEAT_ONE : BEAT_ONE;
                end else begin
                    beat_cnt_next = '0;
                    state_next    = ST_ARB;
                    if (grant_cpu)
                        dma_wait_next = dma_req ? WAIT_ONE : '0;
                end
            end
            default: begin
                state_next = ST_ARB;
            end
        endcase
    end

    // Output logic. The grant decision is taken here, and reset forces every strobe low.
    always_comb begin
        grant_cpu = 1'b0;
        grant_dma = 1'b0;
        if (reset) begin
            case (state_reg)
                ST_ARB: begin
                    if (cpu_req && (!dma_req || (dma_wait_reg < WAIT_MAX)))
                        grant_cpu = 1'b1;
                    else if (dma_req)
                        grant_dma = 1'b1;
                end
                ST_BURST: begin
                    if (dma_req && ((beat_cnt_reg < BEAT_MAX) || !cpu_req))
                        grant_dma = 1'b1;
                    else if (cpu_req)
                        grant_cpu = 1'b1;
                end
                default: ;
            endcase
        end

        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_cpu) begin
            mem_read  = ~cpu_we;
            mem_write = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (grant_dma) begin
            mem_read  = ~dma_we;
            mem_write = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end

        cpu_stall = reset & cpu_req & ~grant_cpu;
        dma_gnt   = grant_dma;
    end

    assign cpu_rdata  = mem_rdata;
    assign dma_rdata  = dma_rdata_reg;
    assign dma_rvalid = dma_rvalid_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MB = 8;
    localparam int SL = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          cpu_stall;
    logic          dma_req, dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata, dma_rdata;
    logic          dma_gnt, dma_rvalid;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h0001_0101;
    endfunction

    // Environment memory: 64 words, combinational read, write at the clock edge.
    logic [31:0] mem [64];
    logic        mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
            mem_ready <= 1'b1;
        end else if (mem_write) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr[7:2]];

    // Reference model state, kept in terms of the arbitration rules.
    logic [31:0] ref_mem [64];
    bit          m_burst;      // DMA currently owns a burst
    int          m_run;        // DMA beats granted since the burst began
    int          m_waited;     // CPU wins while DMA pending since last DMA grant
    bit          m_rvalid;
    logic [31:0] m_rdata;
    bit          m_cpu_win, m_dma_win;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_burst  = 0;
        m_run    = 0;
        m_waited = 0;
        m_rvalid = 0;
        m_rdata  = '0;
    endtask

    // Evaluate one cycle at the falling edge: predict, compare, advance model.
    task automatic eval();
        logic        act, exp_we;
        logic [31:0] exp_addr, exp_wdata;
        @(negedge clk);
        if (!m_burst) begin
            m_cpu_win = cpu_req && (!dma_req || m_waited < SL);
            m_dma_win = !m_cpu_win && dma_req;
        end else begin
            // The CPU may cut in only at a burst boundary (every MB beats).
            m_dma_win = dma_req && (((m_run % MB) != 0) || !cpu_req);
            m_cpu_win = !m_dma_win && cpu_req;
        end
        act       = m_cpu_win || m_dma_win;
        exp_we    = m_cpu_win ? cpu_we    : (m_dma_win ? dma_we    : 1'b0);
        exp_addr  = m_cpu_win ? cpu_addr  : (m_dma_win ? dma_addr  : 32'h0);
        exp_wdata = m_cpu_win ? cpu_wdata : (m_dma_win ? dma_wdata : 32'h0);

        chk("dma_gnt",    32'(dma_gnt),    32'(m_dma_win));
        chk("cpu_stall",  32'(cpu_stall),  32'(cpu_req && !m_cpu_win));
        chk("mem_read",   32'(mem_read),   32'(act && !exp_we));
        chk("mem_write",  32'(mem_write),  32'(act && exp_we));
        chk("mem_addr",   mem_addr,        exp_addr);
        chk("mem_wdata",  mem_wdata,       exp_wdata);
        chk("dma_rvalid", 32'(dma_rvalid), 32'(m_rvalid));
        chk("dma_rdata",  dma_rdata,       m_rdata);
        if (m_cpu_win && !cpu_we)
            chk("cpu_rdata", cpu_rdata, ref_mem[cpu_addr[7:2]]);

        if (m_dma_win) begin
            if (!m_burst) begin
                m_burst  = 1;
                m_run    = 1;
                m_waited = 0;
            end else begin
                m_run++;
            end
        end else begin
            m_burst = 0;
            m_run   = 0;
            if (m_cpu_win && dma_req && m_waited < SL) m_waited++;
        end
        m_rvalid = m_dma_win && !dma_we;
        if (m_rvalid) m_rdata = ref_mem[dma_addr[7:2]];
        if (m_cpu_win && cpu_we) ref_mem[cpu_addr[7:2]] = cpu_wdata;
        if (m_dma_win && dma_we) ref_mem[dma_addr[7:2]] = dma_wdata;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    bit last_dma_win;

    initial begin
        reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        model_reset();

        // Reset state: requests present but everything held low.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_read",   32'(mem_read),   32'h0);
        chk("rst_mem_write",  32'(mem_write),  32'h0);
        chk("rst_dma_gnt",    32'(dma_gnt),    32'h0);
        chk("rst_cpu_stall",  32'(cpu_stall),  32'h0);
        chk("rst_dma_rvalid", 32'(dma_rvalid), 32'h0);
        chk("rst_dma_rdata",  dma_rdata,       32'h0);
        cpu_req = 1'b0; dma_req = 1'b0;
        reset = 1'b1;
        adv();

        // CPU-only write.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hA5;
        eval();
        chk("t1_mem_write", 32'(mem_write), 32'h1);
        chk("t1_mem_addr",  mem_addr,       32'h10);
        chk("t1_cpu_stall", 32'(cpu_stall), 32'h0);
        adv();

        // Starvation: CPU wins cycles 0-3, DMA bursts 4-11, CPU 12-15, DMA at 16.
        cpu_we = 1'b0; cpu_addr = 32'h40;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h80; dma_wdata = 32'h5555;
        for (int k = 0; k < 17; k++) begin
            eval();
            chk("t2_dma_gnt",   32'(dma_gnt),   32'((k >= 4 && k < 12) || k == 16));
            chk("t2_cpu_stall", 32'(cpu_stall), 32'((k >= 4 && k < 12) || k == 16));
            adv();
        end

        // DMA write 0x1234 to 0x20, then read it back.
        cpu_req = 1'b0;
        dma_we = 1'b1; dma_addr = 32'h20; dma_wdata = 32'h1234;
        eval(); adv();
        dma_we = 1'b0;
        eval();
        chk("t3_dma_gnt", 32'(dma_gnt), 32'h1);
        adv();
        dma_req = 1'b0;
        eval();
        chk("t3_rvalid", 32'(dma_rvalid), 32'h1);
        chk("t3_rdata",  dma_rdata,       32'h1234);
        adv();
        eval();
        chk("t3_rvalid_pulse", 32'(dma_rvalid), 32'h0);
        adv();

        // DMA-only stream of 20 beats without gaps.
        dma_req = 1'b1; dma_we = 1'b0;
        for (int k = 0; k < 20; k++) begin
            dma_addr = 32'(k * 4);
            eval();
            chk("t4_dma_gnt", 32'(dma_gnt), 32'h1);
            adv();
        end
        dma_req = 1'b0;
        eval(); adv();

        // Burst ends early after 3 beats. The CPU is served at once, and the arbiter is back in ARB.
        dma_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            dma_addr = 32'(32'h60 + k * 4);
            eval(); adv();
        end
        dma_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        eval();
        chk("t5_cpu_stall", 32'(cpu_stall), 32'h0);
        chk("t5_cpu_rdata", cpu_rdata,      32'hA5);
        adv();
        dma_req = 1'b1;
        eval();
        chk("t5_arb_cpu", 32'(cpu_stall), 32'h0);
        chk("t5_arb_dma", 32'(dma_gnt),   32'h0);
        adv();

        // Async reset mid-burst aborts the in-flight write beat.
        cpu_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h30;
        for (int k = 0; k < 3; k++) begin
            eval(); adv();
        end
        dma_we = 1'b1; dma_addr = 32'hF0; dma_wdata = 32'hDEAD;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        #2 reset = 1'b0;
        #1;
        chk("t6_mem_write",  32'(mem_write),  32'h0);
        chk("t6_mem_read",   32'(mem_read),   32'h0);
        chk("t6_dma_gnt",    32'(dma_gnt),    32'h0);
        chk("t6_cpu_stall",  32'(cpu_stall),  32'h0);
        chk("t6_dma_rvalid", 32'(dma_rvalid), 32'h0);
        model_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        eval();
        chk("t6_cpu_first", 32'(cpu_stall), 32'h0);
        chk("t6_dma_wait",  32'(dma_gnt),   32'h0);
        adv();
        cpu_req = 1'b0; dma_we = 1'b0; dma_addr = 32'hF0;
        eval(); adv();
        dma_req = 1'b0;
        eval();
        chk("t6_not_written", dma_rdata, init_word(60));
        adv();

        // Randomized traffic; the DMA holds its request until granted.
        last_dma_win = 0;
        for (int i = 0; i < 3000; i++) begin
            cpu_req   = ($urandom_range(0, 3) != 0);
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            cpu_wdata = $urandom;
            if (!dma_req || last_dma_win) begin
                dma_req   = ($urandom_range(0, 2) != 0);
                dma_we    = 1'($urandom_range(0, 1));
                dma_addr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
                dma_wdata = $urandom;
            end
            eval();
            last_dma_win = m_dma_win;
            adv();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
